// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for a multicycle RV32I datapath.
// Ports: clk, rst (async, active-low); op/funct3/funct7 from the instruction register;
//   Zero/ALUResSign from the ALU; PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite enables;
//   ALUSrcA/ALUSrcB/ResultSrc/ImmSrc/ALUControl datapath selects; CurState for observation.
// Option: define ILLEGAL_INSTR_HALT_EN to trap illegal op/funct3 in HALT until reset;
//   otherwise an illegal instruction retires as a 2-cycle NOP.
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       Zero,
  input  logic       ALUResSign,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [2:0] ImmSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] CurState
);
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEMADR    = 4'd2,
    S_MEMREAD   = 4'd3,
    S_MEMWB     = 4'd4,
    S_MEMWRITE  = 4'd5,
    S_EXECUTER  = 4'd6,
    S_EXECUTEI  = 4'd7,
    S_ALUWB     = 4'd8,
    S_BRANCH    = 4'd9,
    S_JAL       = 4'd10,
    S_JALR_CALC = 4'd11,
    S_JALR_JUMP = 4'd12,
    S_LUI       = 4'd13,
    S_HALT      = 4'd14
  } state_t;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
`ifdef ILLEGAL_INSTR_HALT_EN
  localparam state_t S_ILLEGAL = S_HALT;
`else
  localparam state_t S_ILLEGAL = S_FETCH;
`endif
  state_t     r_state;
  state_t     w_next;
  logic       w_pcwrite;
  logic       w_irwrite;
  logic       w_memwrite;
  logic       w_regwrite;
  logic       w_f7_rsvd;
  logic       w_sub;
  logic [2:0] w_alu;
  logic       w_alu_ok;
  logic       w_take;
  logic       w_br_ok;
  // Only funct7[5] selects sub; the remaining bits carry no meaning in this ISA subset.
  assign w_f7_rsvd = |{funct7[6], funct7[4:0]};
  assign w_sub     = (op == OP_R) & (funct7[5] | (w_f7_rsvd & 1'b0));
  assign w_alu     = funct3 == 3'b000 ? {2'b00, w_sub} :
                     funct3 == 3'b111 ? 3'b010 :
                     funct3 == 3'b110 ? 3'b011 :
                     funct3 == 3'b100 ? 3'b100 : 3'b101;
  assign w_alu_ok  = funct3 inside {3'b000, 3'b111, 3'b110, 3'b100, 3'b010};
  assign w_take    = funct3 == 3'b000 ? Zero :
                     funct3 == 3'b001 ? ~Zero :
                     funct3 == 3'b100 ? ALUResSign : ~ALUResSign;
  assign w_br_ok   = funct3 inside {3'b000, 3'b001, 3'b100, 3'b101};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;
  end
  always_comb begin
    w_next     = S_FETCH;
    w_pcwrite  = 1'b0;
    w_irwrite  = 1'b0;
    w_memwrite = 1'b0;
    w_regwrite = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ImmSrc     = 3'b000;
    ALUControl = 3'b000;
    case (r_state)
      S_FETCH: begin
        w_irwrite = 1'b1;
        w_pcwrite = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
        ImmSrc  = op == OP_JAL ? 3'b011 : 3'b010;
        case (op)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R:              w_next = w_alu_ok ? S_EXECUTER : S_ILLEGAL;
          OP_I:              w_next = w_alu_ok ? S_EXECUTEI : S_ILLEGAL;
          OP_B:              w_next = w_br_ok ? S_BRANCH : S_ILLEGAL;
          OP_JAL:            w_next = S_JAL;
          OP_JALR:           w_next = S_JALR_CALC;
          OP_LUI:            w_next = S_LUI;
          default:           w_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ImmSrc  = op == OP_STORE ? 3'b001 : 3'b000;
        w_next  = op == OP_STORE ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = 2'b01;
        w_regwrite = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc     = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA    = 2'b10;
        ALUControl = w_alu;
        w_next     = S_ALUWB;
      end
      S_EXECUTEI: begin
        ALUSrcA    = 2'b10;
        ALUSrcB    = 2'b01;
        ALUControl = w_alu;
        w_next     = S_ALUWB;
      end
      S_ALUWB: w_regwrite = 1'b1;
      // Branch resolves in one cycle: the ALU compares rs1-rs2 while PCWrite
      // follows the live flags, so the PC takes the target computed in DECODE.
      S_BRANCH: begin
        ALUSrcA    = 2'b10;
        ALUControl = 3'b001;
        w_pcwrite  = w_take;
      end
      S_JAL, S_JALR_JUMP: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        w_pcwrite = 1'b1;
        w_next    = S_ALUWB;
      end
      S_JALR_CALC: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        w_next  = S_JALR_JUMP;
      end
      S_LUI: begin
        ImmSrc     = 3'b100;
        ResultSrc  = 2'b11;
        w_regwrite = 1'b1;
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_FETCH;
    endcase
  end
  // Architectural enables are held off for as long as reset is asserted.
  assign PCWrite  = rst & w_pcwrite;
  assign IRWrite  = rst & w_irwrite;
  assign MemWrite = rst & w_memwrite;
  assign RegWrite = rst & w_regwrite;
  assign CurState = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for multicycle_controller; expected
// per-cycle {CurState, controls} rows are queued by the driver and popped by a monitor.
module tb_multicycle_controller;
  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       Zero;
  logic       ALUResSign;
  logic       PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ImmSrc, ALUControl;
  logic [3:0] CurState;
  int checks = 0;
  int errors = 0;
  int tn = 0;
  typedef struct {
    int          id;
    logic [20:0] v;
  } exp_t;
  exp_t q[$];
  // Row layout: {PCW,IRW,Adr,MW,RW}_{SrcA}_{SrcB}_{Res}_{Imm}_{ALU}
  localparam logic [16:0] C_F   = 17'b11000_00_10_10_000_000;
  localparam logic [16:0] C_FG  = 17'b00000_00_10_10_000_000;
  localparam logic [16:0] C_D   = 17'b00000_01_01_00_010_000;
  localparam logic [16:0] C_DJ  = 17'b00000_01_01_00_011_000;
  localparam logic [16:0] C_MA  = 17'b00000_10_01_00_000_000;
  localparam logic [16:0] C_MAS = 17'b00000_10_01_00_001_000;
  localparam logic [16:0] C_MR  = 17'b00100_00_00_00_000_000;
  localparam logic [16:0] C_MWB = 17'b00001_00_00_01_000_000;
  localparam logic [16:0] C_MW  = 17'b00110_00_00_00_000_000;
  localparam logic [16:0] C_ER  = 17'b00000_10_00_00_000_000;
  localparam logic [16:0] C_EI  = 17'b00000_10_01_00_000_000;
  localparam logic [16:0] C_WB  = 17'b00001_00_00_00_000_000;
  localparam logic [16:0] C_BR  = 17'b00000_10_00_00_000_001;
  localparam logic [16:0] C_J   = 17'b10000_01_10_00_000_000;
  localparam logic [16:0] C_L   = 17'b00001_00_00_11_100_000;
  multicycle_controller dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7(funct7),
    .Zero(Zero), .ALUResSign(ALUResSign),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .ALUControl(ALUControl), .CurState(CurState)
  );
  always #5 clk = ~clk;
  function automatic logic [20:0] got();
    return {CurState, PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite,
            ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};
  endfunction
  task automatic chk(input string name, input int id, input logic [20:0] g, input logic [20:0] w);
    checks++;
    if (g !== w) begin
      errors++;
      $display("FAIL %s test %0d: got state %0d ctl %b, want state %0d ctl %b",
               name, id, g[20:17], g[16:0], w[20:17], w[16:0]);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("row", e.id, got(), e.v);
    end
  end
  task automatic pe(input logic [3:0] st, input logic [16:0] c);
    exp_t e;
    e.id = tn;
    e.v  = {st, c};
    q.push_back(e);
  endtask
  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                       input logic z, input logic s);
    op = o; funct3 = f3; funct7 = f7; Zero = z; ALUResSign = s;
  endtask
  task automatic waitq();
    for (int i = 0; i < 20 && q.size() > 0; i++) begin
      @(negedge clk);
      #2;
    end
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout test %0d: %0d rows left, want 0", tn, q.size());
      q.delete();
    end
  endtask
  task automatic go(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                    input logic z, input logic s);
    drive(o, f3, f7, z, s);
    waitq();
    @(posedge clk);
    #1;
    tn++;
  endtask
  task automatic rtype(input logic [2:0] f3, input logic [6:0] f7, input logic [2:0] alu);
    pe(0, C_F); pe(1, C_D); pe(6, C_ER | {14'b0, alu}); pe(8, C_WB);
    go(7'b0110011, f3, f7, 1'b0, 1'b0);
  endtask
  task automatic itype(input logic [2:0] f3, input logic [6:0] f7, input logic [2:0] alu);
    pe(0, C_F); pe(1, C_D); pe(7, C_EI | {14'b0, alu}); pe(8, C_WB);
    go(7'b0010011, f3, f7, 1'b0, 1'b0);
  endtask
  task automatic branch(input logic [2:0] f3, input logic z, input logic s, input logic pcw);
    pe(0, C_F); pe(1, C_D); pe(9, C_BR | {pcw, 16'b0});
    go(7'b1100011, f3, 7'b0, z, s);
  endtask
  task automatic illegal(input logic [6:0] o, input logic [2:0] f3);
    pe(0, C_F); pe(1, C_D);
`ifdef ILLEGAL_INSTR_HALT_EN
    pe(14, 17'b0); pe(14, 17'b0); pe(14, 17'b0);
    drive(o, f3, 7'b0, 1'b0, 1'b0);
    waitq();
    rst = 1'b0;
    pe(0, C_FG);
    waitq();
    @(posedge clk);
    #1;
    rst = 1'b1;
    tn++;
`else
    go(o, f3, 7'b0, 1'b0, 1'b0);
`endif
  endtask
  initial begin
    rst = 1'b0;
    drive(7'b0, 3'b0, 7'b0, 1'b0, 1'b0);
    pe(0, C_FG);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    tn++;
    rtype(3'b000, 7'b0000000, 3'b000);
    rtype(3'b000, 7'b0100000, 3'b001);
    rtype(3'b110, 7'b0000000, 3'b011);
    rtype(3'b010, 7'b0000000, 3'b101);
    itype(3'b100, 7'b0000000, 3'b100);
    itype(3'b111, 7'b0000000, 3'b010);
    itype(3'b000, 7'b0100000, 3'b000);
    pe(0, C_F); pe(1, C_D); pe(2, C_MA); pe(3, C_MR); pe(4, C_MWB);
    go(7'b0000011, 3'b010, 7'b0, 1'b0, 1'b0);
    branch(3'b000, 1'b1, 1'b0, 1'b1);
    branch(3'b000, 1'b0, 1'b0, 1'b0);
    branch(3'b100, 1'b0, 1'b1, 1'b1);
    branch(3'b001, 1'b0, 1'b0, 1'b1);
    branch(3'b101, 1'b0, 1'b1, 1'b0);
    pe(0, C_F); pe(1, C_DJ); pe(10, C_J); pe(8, C_WB);
    go(7'b1101111, 3'b000, 7'b0, 1'b0, 1'b0);
    pe(0, C_F); pe(1, C_D); pe(11, C_MA); pe(12, C_J); pe(8, C_WB);
    go(7'b1100111, 3'b000, 7'b0, 1'b0, 1'b0);
    pe(0, C_F); pe(1, C_D); pe(13, C_L);
    go(7'b0110111, 3'b000, 7'b0, 1'b0, 1'b0);
    // Store interrupted by reset while in MEMWRITE.
    pe(0, C_F); pe(1, C_D); pe(2, C_MAS); pe(5, C_MW);
    drive(7'b0100011, 3'b010, 7'b0, 1'b0, 1'b0);
    waitq();
    rst = 1'b0;
    #1;
    chk("async_rst", tn, got(), {4'd0, C_FG});
    pe(0, C_FG);
    waitq();
    rst = 1'b1;
    #1;
    chk("rst_release", tn, got(), {4'd0, C_F});
    drive(7'b0110111, 3'b000, 7'b0, 1'b0, 1'b0);
    pe(1, C_D); pe(13, C_L);
    waitq();
    @(posedge clk);
    #1;
    tn++;
    illegal(7'b0110011, 3'b001);
    illegal(7'b1100011, 3'b010);
    illegal(7'b0000000, 3'b000);
    rtype(3'b111, 7'b0000000, 3'b010);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
